// File: rtl/apb_timer_mch.sv
// Multi-channel APB timer: NUM_CH prescaled up-counters with auto-reload, one-shot and W1C status.
// Latency: zero-wait-state APB (PREADY = PSEL & PENABLE); irq is registered, one cycle after a flag change.
// Backpressure: none; every access completes in its access phase, counters run regardless of bus traffic.
module apb_timer_mch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

  // Address decode: only PADDR[8:2] is meaningful
  logic [6:0]  word_addr;
  logic        status_hit;
  logic        ch_space;
  logic [3:0]  ch_idx;
  logic [1:0]  reg_idx;
  logic        wr_acc;
  logic        unused_addr;

  assign word_addr   = PADDR[8:2];
  assign status_hit  = (word_addr == 7'h40);
  assign ch_space    = ~PADDR[8];
  assign ch_idx      = PADDR[7:4];
  assign reg_idx     = PADDR[3:2];
  assign wr_acc      = PSEL & PENABLE & PWRITE;
  assign unused_addr = ^{PADDR[31:9], PADDR[1:0]};

  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] ie_vec;
  logic [NUM_CH-1:0] w1c;
  logic [NUM_CH-1:0] status_q, status_d;
  logic              irq_q, irq_d;
  logic [31:0]       ch_rd [NUM_CH];
  logic [31:0]       rdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             wr_hit, wr_ctrl, wr_psc, wr_arr;
    logic             en_q, en_d, os_q, os_d, ie_q, ie_d;
    logic [PSC_W-1:0] psc_q, psc_d, pcnt_q, pcnt_d;
    logic [CNT_W-1:0] arr_q, arr_d, cnt_q, cnt_d;
    logic             ev;

    assign wr_hit  = wr_acc & ch_space & (ch_idx == 4'(g));
    assign wr_ctrl = wr_hit & (reg_idx == 2'd0);
    assign wr_psc  = wr_hit & (reg_idx == 2'd1);
    assign wr_arr  = wr_hit & (reg_idx == 2'd2);

    // Prescale/count step, then software writes layered on top (CLR and CTRL write take priority)
    always_comb begin
      en_d   = en_q;
      os_d   = os_q;
      ie_d   = ie_q;
      psc_d  = psc_q;
      arr_d  = arr_q;
      cnt_d  = cnt_q;
      pcnt_d = pcnt_q;
      ev     = 1'b0;
      if (en_q) begin
        if (pcnt_q == psc_q) begin
          pcnt_d = '0;
          // >= so an ARR lowered below CNT wraps on the next tick instead of overrunning
          if (cnt_q >= arr_q) begin
            cnt_d = '0;
            ev    = 1'b1;
            if (os_q) en_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          pcnt_d = pcnt_q + PSC_ONE;
        end
      end
      if (wr_ctrl) begin
        en_d = PWDATA[0];
        os_d = PWDATA[2];
        ie_d = PWDATA[3];
        if (PWDATA[1]) begin
          pcnt_d = '0;
          cnt_d  = '0;
          ev     = 1'b0;
        end
      end
      if (wr_psc) psc_d = PWDATA[PSC_W-1:0];
      if (wr_arr) arr_d = PWDATA[CNT_W-1:0];
    end

    // Channel state registers
    always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
        en_q   <= 1'b0;
        os_q   <= 1'b0;
        ie_q   <= 1'b0;
        psc_q  <= '0;
        arr_q  <= '0;
        cnt_q  <= '0;
        pcnt_q <= '0;
      end else begin
        en_q   <= en_d;
        os_q   <= os_d;
        ie_q   <= ie_d;
        psc_q  <= psc_d;
        arr_q  <= arr_d;
        cnt_q  <= cnt_d;
        pcnt_q <= pcnt_d;
      end
    end

    assign evt[g]    = ev;
    assign ie_vec[g] = ie_q;
    assign ch_rd[g]  = (reg_idx == 2'd0) ? {28'd0, ie_q, os_q, 1'b0, en_q} :
                       (reg_idx == 2'd1) ? 32'(psc_q) :
                       (reg_idx == 2'd2) ? 32'(arr_q) : 32'(cnt_q);
  end

  assign w1c = (wr_acc & status_hit) ? PWDATA[NUM_CH-1:0] : '0;

  // Status next state: a hardware event beats a same-cycle W1C; irq follows registered flags
  always_comb begin
    status_d = (status_q & ~w1c) | evt;
    irq_d    = |(status_q & ie_vec);
  end

  // Shared status flags and interrupt line
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  // Read mux: combinational from the address during a read, zero otherwise or when unmapped
  always_comb begin
    rdata = '0;
    if (PSEL & ~PWRITE) begin
      if (status_hit) begin
        rdata = 32'(status_q);
      end else if (ch_space) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx == 4'(i)) rdata = ch_rd[i];
        end
      end
    end
  end

  assign PRDATA = rdata;
  assign PREADY = PSEL & PENABLE & ~PRESET;
  assign irq    = irq_q;

endmodule
